// File: rtl/sqrt_mant_iter.sv
// ============================================================================
// Module   : sqrt_mant_iter
// Purpose  : Iterative restoring integer square root, one root bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_mant_iter #(
  parameter int WIDTH = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder,
  output logic               exact
);

  localparam int NR = WIDTH / 2;
  localparam int CW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [CW-1:0] LAST = CW'(NR - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [NR+1:0]    prem;
  logic [NR-1:0]    proot;

  logic [NR+1:0]    r_sh;
  logic [NR+1:0]    trial;
  logic [NR+2:0]    diff;
  logic             borrow;
  logic [NR+1:0]    next_rem;
  logic [NR-1:0]    next_root;
  logic             unused_bits;

  // Partial remainder stays below 2^NR until the last row, so the top bits
  // of prem never contribute to the shifted remainder.
  assign r_sh      = {prem[NR-1:0], sh[WIDTH-1 -: 2]};
  assign trial     = {proot, 2'b01};
  assign diff      = {1'b0, r_sh} - {1'b0, trial};
  assign borrow    = diff[NR+2];
  assign next_rem  = borrow ? r_sh : diff[NR+1:0];
  assign next_root = {proot[NR-2:0], ~borrow};
  assign unused_bits = ^{prem[NR+1:NR], proot[NR-1]};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      prem      <= '0;
      proot     <= '0;
      root      <= '0;
      remainder <= '0;
      exact     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= radicand;
            prem  <= '0;
            proot <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          prem  <= next_rem;
          proot <= next_root;
          sh    <= {sh[WIDTH-3:0], 2'b00};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            root      <= next_root;
            remainder <= next_rem[NR:0];
            exact     <= (next_rem == '0);
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
